// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl
//   Raster scheduler for the TMDS channel encoders. The horizontal and
//   vertical position counters advance once per accepted pixel strobe.
//   Every output is registered and is loaded from the decode of the
//   current position on the same strobe that advances the counters, so
//   outputs follow a strobe by one clock. Start and stop are aligned to
//   frame boundaries, so the link only ever carries whole frames.
//
// Ports
//   clk_i      clock
//   rst_i      asynchronous active-high reset
//   rdy_i      pixel strobe; one raster position is consumed per cycle with rdy_i=1
//   en_i       run request; only sampled on strobes
//   de_o       data enable for the emitted position
//   hsync_o    horizontal sync, active level SYNC_POL
//   vsync_o    vertical sync, active level SYNC_POL, asserted for whole lines
//   x_o, y_o   emitted position
//   sof_o      emitted position is (0,0)
//   eol_o      emitted position is the last pixel of a line
//   running_o  controller is in RUN or STOP_PEND
module video_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rdy_i,
  input  logic             en_i,
  output logic             de_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             sof_o,
  output logic             eol_o,
  output logic             running_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             SYNC_IDLE = ~SYNC_POL;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_PEND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;

  logic             de_q, de_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             sof_q, sof_d;
  logic             eol_q, eol_d;
  logic             running_q, running_d;

  // Decode of the current counter position
  logic pos_de, pos_hs_act, pos_vs_act, pos_sof, pos_eol;
  logic h_last, v_last;
  logic load_pos, load_idle;

  always_comb begin
    pos_de     = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
    pos_hs_act = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
    pos_vs_act = (vcnt_q >= VS_START) && (vcnt_q < VS_END);
    pos_sof    = (hcnt_q == '0) && (vcnt_q == '0);
    pos_eol    = (hcnt_q == H_LAST);
    h_last     = (hcnt_q == H_LAST);
    v_last     = (vcnt_q == V_LAST);
  end

  // Next state, counters and load selects
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    load_pos  = 1'b0;
    load_idle = 1'b0;

    if (rdy_i) begin
      case (state_q)
        ST_IDLE: begin
          // Counters sit at (0,0) here, so a start emits the frame origin.
          if (en_i) begin
            load_pos = 1'b1;
            state_d  = ST_RUN;
          end
        end
        ST_RUN: begin
          load_pos = 1'b1;
          state_d  = en_i ? ST_RUN : ST_STOP_PEND;
        end
        ST_STOP_PEND: begin
          // Counters at the origin while stop is pending can only mean the
          // last position of the frame has already gone out: drop to idle
          // instead of starting another frame.
          if (pos_sof) begin
            load_idle = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            load_pos = 1'b1;
            state_d  = en_i ? ST_RUN : ST_STOP_PEND;
          end
        end
        default: begin
          load_idle = 1'b1;
          state_d   = ST_IDLE;
        end
      endcase
    end

    if (load_pos) begin
      if (h_last) begin
        hcnt_d = '0;
        vcnt_d = v_last ? '0 : (vcnt_q + CNT_ONE);
      end else begin
        hcnt_d = hcnt_q + CNT_ONE;
      end
    end else if (load_idle) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end
  end

  // Output next values: hold unless a strobe loads a position or idle values
  always_comb begin
    de_d      = de_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    x_d       = x_q;
    y_d       = y_q;
    sof_d     = sof_q;
    eol_d     = eol_q;
    running_d = running_q;

    if (load_pos) begin
      de_d      = pos_de;
      hsync_d   = pos_hs_act ? SYNC_POL : SYNC_IDLE;
      vsync_d   = pos_vs_act ? SYNC_POL : SYNC_IDLE;
      x_d       = hcnt_q;
      y_d       = vcnt_q;
      sof_d     = pos_sof;
      eol_d     = pos_eol;
      running_d = 1'b1;
    end else if (load_idle) begin
      de_d      = 1'b0;
      hsync_d   = SYNC_IDLE;
      vsync_d   = SYNC_IDLE;
      x_d       = '0;
      y_d       = '0;
      sof_d     = 1'b0;
      eol_d     = 1'b0;
      running_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      de_q      <= 1'b0;
      hsync_q   <= SYNC_IDLE;
      vsync_q   <= SYNC_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      de_q      <= de_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      x_q       <= x_d;
      y_q       <= y_d;
      sof_q     <= sof_d;
      eol_q     <= eol_d;
      running_q <= running_d;
    end
  end

  assign de_o      = de_q;
  assign hsync_o   = hsync_q;
  assign vsync_o   = vsync_q;
  assign x_o       = x_q;
  assign y_o       = y_q;
  assign sof_o     = sof_q;
  assign eol_o     = eol_q;
  assign running_o = running_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Self-checking bench for video_timing_ctrl with a small 8x6 raster.
module tb_video_timing_ctrl;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;   // 8
  localparam int VT = VA + VF + VS + VB;   // 6
  localparam int FR = HT * VT;             // 48 positions per frame
  localparam int CW = 11;

  logic          clk_i = 1'b0;
  logic          rst_i, rdy_i, en_i;
  logic          de_o, hsync_o, vsync_o, sof_o, eol_o, running_o;
  logic [CW-1:0] x_o, y_o;

  video_timing_ctrl #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b0), .CNT_W(CW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rdy_i(rdy_i), .en_i(en_i),
    .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .x_o(x_o), .y_o(y_o), .sof_o(sof_o), .eol_o(eol_o),
    .running_o(running_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a linear raster index plus run/stop flags.
  bit m_active, m_stop;
  int m_next;
  bit e_de, e_hs, e_vs, e_sof, e_eol, e_run;
  int e_x, e_y;

  typedef struct {
    bit rdy; bit en;
    int x; int y;
    bit de; bit hs; bit vs; bit sof; bit eol; bit run;
  } vec_t;
  vec_t tbl[12];

  function automatic vec_t mk(bit rdy, bit en, int x, int y, bit de, bit hs,
                              bit vs, bit sof, bit eol, bit run);
    vec_t v;
    v.rdy = rdy; v.en = en; v.x = x; v.y = y; v.de = de; v.hs = hs;
    v.vs = vs; v.sof = sof; v.eol = eol; v.run = run;
    return v;
  endfunction

  function automatic void model_idle();
    e_de = 0; e_hs = 1; e_vs = 1; e_x = 0; e_y = 0;
    e_sof = 0; e_eol = 0; e_run = 0;
  endfunction

  function automatic void model_reset();
    m_active = 0; m_stop = 0; m_next = 0;
    model_idle();
  endfunction

  function automatic void model_emit(int p);
    e_x   = p % HT;
    e_y   = p / HT;
    e_de  = (e_x < HA) && (e_y < VA);
    e_hs  = !((e_x >= HA + HF) && (e_x < HA + HF + HS));
    e_vs  = !((e_y >= VA + VF) && (e_y < VA + VF + VS));
    e_sof = (p == 0);
    e_eol = (e_x == HT - 1);
    e_run = 1;
  endfunction

  function automatic void model_strobe(bit en_s);
    if (!m_active) begin
      if (en_s) begin
        model_emit(0);
        m_active = 1; m_next = 1; m_stop = 0;
      end
    end else if (m_stop && m_next == 0) begin
      model_idle();
      m_active = 0;
    end else begin
      model_emit(m_next);
      m_next = (m_next + 1) % FR;
      m_stop = !en_s;
    end
  endfunction

  task automatic cmp(string name, int x, int y, bit de, bit hs, bit vs,
                     bit sof, bit eol, bit run);
    n_tests++;
    if (x_o !== CW'(x) || y_o !== CW'(y) || de_o !== de || hsync_o !== hs ||
        vsync_o !== vs || sof_o !== sof || eol_o !== eol || running_o !== run) begin
      n_fail++;
      $display("FAIL %s: got x=%0d y=%0d de=%b hs=%b vs=%b sof=%b eol=%b run=%b want x=%0d y=%0d de=%b hs=%b vs=%b sof=%b eol=%b run=%b",
               name, x_o, y_o, de_o, hsync_o, vsync_o, sof_o, eol_o, running_o,
               x, y, de, hs, vs, sof, eol, run);
    end
  endtask

  task automatic check_model(string name);
    cmp(name, e_x, e_y, e_de, e_hs, e_vs, e_sof, e_eol, e_run);
  endtask

  task automatic check_val(string name, int got, int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // One clock: inputs driven at the negedge, model steps on the posedge,
  // outputs compared at the following negedge.
  task automatic cyc(bit r, bit e, string name);
    rdy_i = r; en_i = e;
    @(posedge clk_i);
    if (r && !rst_i) model_strobe(e);
    @(negedge clk_i);
    check_model(name);
  endtask

  // Strobe until the model's next emitted index equals target.
  task automatic run_until(int target, bit en_v, string name);
    bit hit = 0;
    for (int i = 0; i < 200; i++) begin
      if (m_active && m_next == target) begin hit = 1; break; end
      cyc(1, en_v, name);
    end
    check_val({name, "_reach"}, int'(hit), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sof_at[$];
    int vs_cnt, strobe_no, guard;

    rst_i = 1; rdy_i = 0; en_i = 0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    cmp("reset_state", 0, 0, 0, 1, 1, 0, 0, 0);
    $display("[TB] reset state checked");
    rst_i = 0;

    // Table: first line from idle, continuous strobes with one gap.
    tbl[0]  = mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 1, 1, 1, 1, 0, 1);
    tbl[2]  = mk(1, 1, 1, 0, 1, 1, 1, 0, 0, 1);
    tbl[3]  = mk(0, 1, 1, 0, 1, 1, 1, 0, 0, 1);
    tbl[4]  = mk(1, 1, 2, 0, 1, 1, 1, 0, 0, 1);
    tbl[5]  = mk(1, 1, 3, 0, 1, 1, 1, 0, 0, 1);
    tbl[6]  = mk(1, 1, 4, 0, 0, 1, 1, 0, 0, 1);
    tbl[7]  = mk(1, 1, 5, 0, 0, 0, 1, 0, 0, 1);
    tbl[8]  = mk(1, 1, 6, 0, 0, 0, 1, 0, 0, 1);
    tbl[9]  = mk(1, 1, 7, 0, 0, 1, 1, 0, 1, 1);
    tbl[10] = mk(1, 1, 0, 1, 1, 1, 1, 0, 0, 1);
    tbl[11] = mk(1, 1, 1, 1, 1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      rdy_i = tbl[i].rdy; en_i = tbl[i].en;
      @(posedge clk_i);
      if (tbl[i].rdy) model_strobe(tbl[i].en);
      @(negedge clk_i);
      cmp($sformatf("table_%0d", i), tbl[i].x, tbl[i].y, tbl[i].de, tbl[i].hs,
          tbl[i].vs, tbl[i].sof, tbl[i].eol, tbl[i].run);
      $display("[TB] table %0d x=%0d y=%0d", i, x_o, y_o);
    end

    // Strobe every 3rd cycle: outputs hold on the two idle cycles.
    for (int i = 0; i < 3 * 20; i++) cyc((i % 3) == 0, 1, "strobe_3rd");
    $display("[TB] strobe every 3rd cycle done");

    // Full frames: sof spacing and vsync line coverage.
    run_until(0, 1, "align_frame");
    vs_cnt = 0; strobe_no = 0;
    for (int i = 0; i < 2 * FR + 1; i++) begin
      cyc(1, 1, "full_frame");
      strobe_no++;
      if (sof_o) sof_at.push_back(strobe_no);
      if (i < FR && vsync_o == 1'b0) begin
        vs_cnt++;
        check_val("vsync_line", int'(y_o), 4);
      end
    end
    check_val("vsync_count", vs_cnt, HT);
    check_val("sof_count", sof_at.size(), 3);
    if (sof_at.size() == 3) begin
      check_val("sof_period_a", sof_at[1] - sof_at[0], FR);
      check_val("sof_period_b", sof_at[2] - sof_at[1], FR);
    end
    $display("[TB] full frame done vsync_lines=%0d sofs=%0d", vs_cnt, sof_at.size());

    // Drop en at (2,1): frame completes, then idle with no sof.
    run_until(10, 1, "to_2_1");
    cyc(1, 0, "drop_en_2_1");
    cmp("emit_2_1", 2, 1, 1, 1, 1, 0, 0, 1);
    guard = 0;
    while (m_active && guard < 100) begin cyc(1, 0, "stop_drain"); guard++; end
    check_val("stop_drain_bounded", int'(guard < 100), 1);
    cmp("stopped_idle", 0, 0, 0, 1, 1, 0, 0, 0);
    cyc(1, 0, "stay_idle");
    cyc(0, 1, "en_no_strobe");
    $display("[TB] stop at frame end done");

    // Variant: stop pending, en re-raised at (0,3): next frame starts normally.
    cyc(1, 1, "restart");
    cyc(1, 0, "drop_again");
    run_until(24, 0, "to_0_3");
    cyc(1, 1, "reraise_0_3");
    run_until(0, 1, "to_wrap");
    cyc(1, 1, "next_frame_sof");
    cmp("next_frame_sof_val", 0, 0, 1, 1, 1, 1, 0, 1);
    $display("[TB] re-raise variant done");

    // Reset pulse right after (5,2) is emitted: asynchronous clear.
    run_until(21, 1, "to_5_2");
    cyc(1, 1, "emit_5_2");
    #2 rst_i = 1;
    #1 cmp("async_reset", 0, 0, 0, 1, 1, 0, 0, 0);
    model_reset();
    for (int i = 0; i < 4; i++) cyc(i[0], 1, "reset_hold");
    @(negedge clk_i);
    rst_i = 0;
    cyc(1, 1, "after_reset_sof");
    cmp("after_reset_origin", 0, 0, 1, 1, 1, 1, 0, 1);
    $display("[TB] reset pulse done");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 39) == 0) en_i = ~en_i;
      cyc(r, en_i, "random");
    end
    $display("[TB] random traffic done");

    // Mid-stream asynchronous reset with strobes toggling.
    cyc(1, 1, "pre_reset_a");
    cyc(1, 1, "pre_reset_b");
    #3 rst_i = 1;
    #1 cmp("mid_reset", 0, 0, 0, 1, 1, 0, 0, 0);
    model_reset();
    for (int i = 0; i < 6; i++) cyc(i[0], 1, "mid_reset_hold");
    @(negedge clk_i);
    rst_i = 0;
    cyc(1, 1, "post_mid_reset");
    $display("[TB] mid-stream reset done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
